spi_cfg_regs: RTL and testbench

SPI-mode-0 write/read configuration front-end that turns serial frames from the off-chip controller into the five 8-bit control registers consumed by the PWM peripheral. It sits directly upstream of the PWM peripheral: pin inputs arrive on `ui_in[2:0]`, and the register outputs drive the PWM block's enable and duty-cycle inputs. Frames are committed atomically only on a clean 16-bit transaction.

---
 rtl/spi_cfg_pkg.sv | 22 ++
 rtl/sync_edge.sv | 35 +++
 rtl/spi_cfg_regs.sv | 174 +++++++++++++++++
 tb/tb_spi_cfg_regs.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM state type for the SPI configuration front-end.
package spi_cfg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam logic [7:0] REG_RST_VAL = 8'h00;
    localparam logic [4:0] CNT_MAX     = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop pin synchronizer with one edge-detect flop producing rise/fall flags.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_cfg_regs.sv
// SPI mode-0 frame receiver driving the five PWM control registers.
// Optional readback path is enabled by defining SPI_CFG_READBACK_EN.
module spi_cfg_regs
    import spi_cfg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .pin(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .pin(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];
    logic        wr_strobe_q, wr_strobe_d;
    logic        frame_err_q, frame_err_d;

`ifdef SPI_CFG_READBACK_EN
    logic [7:0] out_q, out_d;
    logic       cipo_q, cipo_d;
    logic [7:0] rd_byte;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef SPI_CFG_READBACK_EN
        out_d   = out_q;
        cipo_d  = cipo_q;
        rd_byte = REG_RST_VAL;
`endif
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
`ifdef SPI_CFG_READBACK_EN
                    out_d   = '0;
                    cipo_d  = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // A chip-select release in the same cycle as an SCLK edge drops the edge.
                if (ncs_rise) begin
                    state_d = COMMIT;
`ifdef SPI_CFG_READBACK_EN
                    cipo_d  = 1'b0;
`endif
                end else if (sclk_rise && !ncs_lvl) begin
                    shift_d = {shift_q[14:0], copi_lvl};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 5'd1;
                    end
`ifdef SPI_CFG_READBACK_EN
                    if (cnt_q == 5'd7 && !shift_d[7]) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (shift_d[6:0] == 7'(i) && 7'(i) <= MAX_ADDR) begin
                                rd_byte = regs_q[i];
                            end
                        end
                        out_d  = rd_byte;
                        cipo_d = rd_byte[7];
                    end
`endif
                end
`ifdef SPI_CFG_READBACK_EN
                // The fall right after the 8th rise keeps bit7 up for the controller's 9th rise.
                else if (sclk_fall && !ncs_lvl && cnt_q >= 5'd9) begin
                    out_d  = {out_q[6:0], 1'b0};
                    cipo_d = out_q[6];
                end
`endif
            end
            COMMIT: begin
                state_d = IDLE;
                if (cnt_q == 5'(FRAME_BITS)) begin
                    if (shift_q[15] && shift_q[14:8] <= MAX_ADDR) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (shift_q[14:8] == 7'(i)) begin
                                regs_d[i]   = shift_q[7:0];
                                wr_strobe_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_RST_VAL;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_CFG_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            cipo_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cipo_q <= cipo_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    logic unused_edges;
    assign unused_edges = ^{copi_rise, copi_fall, sclk_lvl, sclk_fall};

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Directed plus randomized frames against a register-map reference model for spi_cfg_regs.
module tb_spi_cfg_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    spi_cfg_regs dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_strobe = 0;
    int n_err = 0;
    int exp_strobe = 0;
    int exp_err = 0;
    logic [7:0] model [5];
    logic       cap [32];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) n_strobe++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] regs_now();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] regs_exp();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    // Reference: only a clean 16-bit write to a mapped address changes state.
    task automatic model_frame(input logic [31:0] val, input int n);
        if (n == 16) begin
            if (val[15] && val[14:8] <= 7'h04) begin
                model[val[10:8]] = val[7:0];
                exp_strobe++;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            copi = val[n-1-i];
            tick(4);
            cap[i] = cipo;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    // Leaves ncs just released; caller waits for the commit.
    task automatic send_frame(input logic [31:0] val, input int n);
        ncs = 1'b0;
        tick(4);
        shift_bits(val, n);
        tick(4);
        ncs = 1'b1;
    endtask

    function automatic logic [7:0] read_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = cap[8+i];
        return b;
    endfunction

    task automatic full_frame(input logic [31:0] val, input int n);
        send_frame(val, n);
        model_frame(val, n);
        tick(8);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        tick(4);
        rst = 1'b0;
        tick(2);

        check("reset_regs", regs_now(), 40'h0);
        check("reset_strobe", wr_strobe, 1'b0);
        check("reset_err", frame_err, 1'b0);
        check("reset_cipo", cipo, 1'b0);

        // Duty-cycle write and commit latency relative to the ncs pin edge
        send_frame(32'h8455, 16);
        model_frame(32'h8455, 16);
        tick(3);
        check("duty_before_commit", pwm_duty_cycle, 8'h00);
        tick(1);
        check("duty_at_commit", pwm_duty_cycle, 8'h55);
        check("strobe_at_commit", wr_strobe, 1'b1);
        tick(1);
        check("strobe_one_cycle", wr_strobe, 1'b0);
        tick(6);
        check("first_regs", regs_now(), regs_exp());
        check("first_strobes", n_strobe, 1);

        full_frame(32'h80FF, 16);
        full_frame(32'h810F, 16);
        full_frame(32'h82A5, 16);
        full_frame(32'h833C, 16);
        check("four_writes_regs", regs_now(), regs_exp());
        check("four_writes_strobes", n_strobe, exp_strobe);
        check("four_writes_errs", n_err, 0);

        full_frame(32'h80AA >> 1, 15);
        full_frame((32'h80AA << 1) | 32'h1, 17);
        check("short_long_reg0", en_reg_out_7_0, 8'hFF);
        check("short_long_errs", n_err, 2);
        check("short_long_strobes", n_strobe, exp_strobe);

        full_frame(32'h8799, 16);
        check("unmapped_regs", regs_now(), regs_exp());
        check("unmapped_strobes", n_strobe, exp_strobe);
        check("unmapped_errs", n_err, exp_err);

        // Read frames: readback build returns data, default build ignores them
        full_frame(32'h8466, 16);
        full_frame(32'h0400, 16);
`ifdef SPI_CFG_READBACK_EN
        check("read_duty", read_byte(), 8'h66);
`else
        check("read_disabled_cipo", read_byte(), 8'h00);
`endif
        full_frame(32'h1000, 16);
        check("read_unmapped", read_byte(), 8'h00);
        check("read_no_change", regs_now(), regs_exp());
        check("read_strobes", n_strobe, exp_strobe);
        check("read_errs", n_err, exp_err);
        check("cipo_idle", cipo, 1'b0);

        // Reset in the middle of a frame
        ncs = 1'b0;
        tick(4);
        shift_bits(32'h83C3, 10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        tick(1);
        check("midframe_reset_regs", regs_now(), 40'h0);
        tick(4);
        ncs = 1'b1;
        tick(8);
        check("post_reset_no_err", n_err, exp_err);
        full_frame(32'h8212, 16);
        check("post_reset_pwm_lo", en_reg_pwm_7_0, 8'h12);
        check("post_reset_regs", regs_now(), regs_exp());
        check("post_reset_strobes", n_strobe, exp_strobe);

        // Randomized frames
        for (int k = 0; k < 24; k++) begin
            int          r, n;
            logic [31:0] v;
            logic [7:0]  rd_exp;
            r = $urandom_range(0, 5);
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            v = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            rd_exp = (v[14:8] <= 7'h04) ? model[v[10:8]] : 8'h00;
            if (n == 15) v = v >> 1;
            if (n == 17) v = (v << 1) | 32'h1;
            full_frame(v, n);
            check("rand_regs", regs_now(), regs_exp());
`ifdef SPI_CFG_READBACK_EN
            if (n == 16 && !v[15]) check("rand_read", read_byte(), rd_exp);
`else
            if (n == 16 && !v[15]) check("rand_read_off", read_byte(), 8'h00);
`endif
        end
        check("rand_strobes", n_strobe, exp_strobe);
        check("rand_errs", n_err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
